clk_rate_governor: RTL and testbench

- Adaptive clock-enable generator for the green CPU's power path. It sits directly downstream of the fixed toggle divider and replaces its single hard-wired terminal count.
- It produces a one-cycle `tick` enable and a toggling `clk` output at one of three selectable rates.
- It steps the rate down after sustained CPU idleness and snaps back to full rate as soon as activity or a wake request appears.
- All logic runs in the `clk_signal` domain; `tick` is the enable consumed by the CPU core and peripherals.

---
 rtl/clk_rate_governor.sv | 97 +++++++++
 tb/tb_clk_rate_governor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_governor.sv
// Adaptive clock-enable generator: divides clk_signal by one of three rates,
// stepping down after sustained idleness and snapping back to full rate on activity or wake.
module clk_rate_governor #(
  parameter int CNT_W      = 27,
  parameter int DIV_FAST   = 4,
  parameter int DIV_MID    = 8,
  parameter int DIV_SLOW   = 16,
  parameter int IDLE_TICKS = 3
) (
  input  logic       clk_signal,
  input  logic       reset,
  input  logic       busy,
  input  logic       wake,
  output logic       tick,
  output logic       clk,
  output logic [1:0] mode,
  output logic       mode_chg
);

  typedef enum logic [1:0] {
    FAST = 2'd0,
    MID  = 2'd1,
    SLOW = 2'd2
  } rate_t;

  localparam int IW = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;

  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(DIV_MID - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TICKS - 1);

  rate_t            rate;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] last;
  logic [IW-1:0]    idle_cnt;
  logic             at_last;
  logic             upshift;

  always_comb begin
    last = FAST_LAST;
    case (rate)
      MID:     last = MID_LAST;
      SLOW:    last = SLOW_LAST;
      default: last = FAST_LAST;
    endcase
  end

  assign at_last = (counter == last);
  assign upshift = (busy || wake) && (rate != FAST);
  assign mode    = rate;

  // NOTE: non-blocking assignments throughout, so every branch below reads the
  // pre-edge values of counter, rate and idle_cnt regardless of statement order.
  always_ff @(posedge clk_signal) begin
    if (reset) begin
      rate     <= FAST;
      counter  <= '0;
      idle_cnt <= '0;
      tick     <= 1'b0;
      clk      <= 1'b0;
      mode_chg <= 1'b0;
    end else if (upshift) begin
      // Returning to full rate restarts the period and suppresses a coincident tick.
      rate     <= FAST;
      counter  <= '0;
      idle_cnt <= '0;
      tick     <= 1'b0;
      mode_chg <= 1'b1;
    end else begin
      mode_chg <= 1'b0;
      if (at_last) begin
        counter <= '0;
        tick    <= 1'b1;
        clk     <= ~clk;
        if (busy || wake) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IDLE_LAST) begin
          idle_cnt <= '0;
          if (rate != SLOW) begin
            rate     <= (rate == FAST) ? MID : SLOW;
            mode_chg <= 1'b1;
          end
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        counter <= counter + 1'b1;
        tick    <= 1'b0;
        if (wake) begin
          idle_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_rate_governor.sv
// Self-checking bench for clk_rate_governor: per-cycle scoreboard against a
// behavioural model, a table of input phases with hand-counted results, and corner sequences.
module tb_clk_rate_governor;

  localparam int CNT_W      = 27;
  localparam int DIV_FAST   = 4;
  localparam int DIV_MID    = 8;
  localparam int DIV_SLOW   = 16;
  localparam int IDLE_TICKS = 3;

  logic       clk_signal = 1'b0;
  logic       reset      = 1'b1;
  logic       busy       = 1'b0;
  logic       wake       = 1'b0;
  logic       tick;
  logic       clk_o;
  logic [1:0] mode;
  logic       mode_chg;

  clk_rate_governor #(
    .CNT_W     (CNT_W),
    .DIV_FAST  (DIV_FAST),
    .DIV_MID   (DIV_MID),
    .DIV_SLOW  (DIV_SLOW),
    .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk_signal(clk_signal),
    .reset     (reset),
    .busy      (busy),
    .wake      (wake),
    .tick      (tick),
    .clk       (clk_o),
    .mode      (mode),
    .mode_chg  (mode_chg)
  );

  always #5 clk_signal = ~clk_signal;

  typedef struct packed {
    logic       tick;
    logic       clk;
    logic [1:0] mode;
    logic       chg;
  } exp_t;

  typedef struct {
    logic r;
    logic b;
    logic w;
    int   n;
    int   ticks;
    int   chgs;
    int   mode;
  } phase_t;

  exp_t   sb[$];
  phase_t phases[5];

  int n_checks = 0;
  int n_fails  = 0;
  int n_cycle  = 0;

  // Behavioural reference state
  int   m_cnt  = 0;
  int   m_idle = 0;
  int   m_mode = 0;
  logic m_clk  = 1'b0;
  logic m_tick = 1'b0;
  logic m_chg  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic b, input logic w);
    int div;
    div = (m_mode == 0) ? DIV_FAST : (m_mode == 1) ? DIV_MID : DIV_SLOW;
    if (r) begin
      m_cnt = 0; m_idle = 0; m_mode = 0; m_clk = 1'b0; m_tick = 1'b0; m_chg = 1'b0;
    end else if ((b || w) && m_mode != 0) begin
      m_mode = 0; m_cnt = 0; m_idle = 0; m_tick = 1'b0; m_chg = 1'b1;
    end else begin
      m_chg = 1'b0;
      if (m_cnt == div - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        m_clk  = ~m_clk;
        if (b || w) m_idle = 0;
        else if (m_idle == IDLE_TICKS - 1) begin
          m_idle = 0;
          if (m_mode < 2) begin
            m_mode = m_mode + 1;
            m_chg  = 1'b1;
          end
        end else m_idle = m_idle + 1;
      end else begin
        m_cnt  = m_cnt + 1;
        m_tick = 1'b0;
        if (w) m_idle = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, and compare after the edge.
  task automatic cycle(input logic r, input logic b, input logic w);
    exp_t e;
    exp_t got;
    reset = r;
    busy  = b;
    wake  = w;
    model_step(r, b, w);
    e.tick = m_tick;
    e.clk  = m_clk;
    e.mode = 2'(m_mode);
    e.chg  = m_chg;
    sb.push_back(e);
    @(posedge clk_signal);
    #1;
    n_cycle++;
    e   = sb.pop_front();
    got = '{tick: tick, clk: clk_o, mode: mode, chg: mode_chg};
    check($sformatf("cycle %0d {tick,clk,mode,chg}", n_cycle), int'(got), int'(e));
  endtask

  task automatic run(input int n, input logic b);
    for (int i = 0; i < n; i++) cycle(1'b0, b, 1'b0);
  endtask

  // Edges from now until tick goes high; 0 if the budget expires.
  task automatic edges_to_tick(input logic b, output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, b, 1'b0);
      if (tick) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int t;
    int c;
    int e;

    // {reset, busy, wake, cycles, expected ticks, expected mode_chg pulses, final mode}
    phases[0] = '{1'b1, 1'b1, 1'b0,  3, 0, 0, 0};
    phases[1] = '{1'b0, 1'b1, 1'b0, 20, 5, 0, 0};
    phases[2] = '{1'b0, 1'b0, 1'b0, 60, 7, 2, 2};
    phases[3] = '{1'b0, 1'b1, 1'b0,  1, 0, 1, 0};
    phases[4] = '{1'b0, 1'b1, 1'b0,  8, 2, 0, 0};

    for (int p = 0; p < 5; p++) begin
      t = 0;
      c = 0;
      for (int i = 0; i < phases[p].n; i++) begin
        cycle(phases[p].r, phases[p].b, phases[p].w);
        t += int'(tick);
        c += int'(mode_chg);
      end
      check($sformatf("phase%0d ticks", p), t, phases[p].ticks);
      check($sformatf("phase%0d mode_chg pulses", p), c, phases[p].chgs);
      check($sformatf("phase%0d mode", p), int'(mode), phases[p].mode);
    end

    // Reset state and first tick after release
    cycle(1'b1, 1'b1, 1'b0);
    check("reset outputs", int'({tick, clk_o, mode, mode_chg}), 0);
    edges_to_tick(1'b1, e);
    check("first tick after reset", e, 4);
    edges_to_tick(1'b1, e);
    check("fast period", e, 4);

    // Mid-period upshift from SLOW at counter 5
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    run(36, 1'b0);
    check("reach slow mode", int'(mode), 2);
    edges_to_tick(1'b0, e);
    check("slow period", e, 16);
    run(5, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("upshift tick", int'(tick), 0);
    check("upshift mode", int'(mode), 0);
    check("upshift mode_chg", int'(mode_chg), 1);
    edges_to_tick(1'b0, e);
    check("tick after upshift", e, 4);

    // Wake beats a pending step-down
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    run(11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("wake tick", int'(tick), 1);
    check("wake mode", int'(mode), 0);
    check("wake mode_chg", int'(mode_chg), 0);
    c = 0;
    for (int i = 0; i < 11; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      c += int'(mode_chg);
    end
    check("no early step-down", c + int'(mode), 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("step-down after wake mode", int'(mode), 1);
    check("step-down after wake mode_chg", int'(mode_chg), 1);
    check("step-down coincides with tick", int'(tick), 1);

    // Upshift overrides a terminal-count tick in MID
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    run(12, 1'b0);
    check("mid mode clk", int'({clk_o, mode}), 3'b101);
    run(7, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("override tick,clk,mode,chg", int'({tick, clk_o, mode, mode_chg}), 5'b01001);

    // Reset mid-operation in MID with clk high
    cycle(1'b1, 1'b0, 1'b0);
    run(12, 1'b0);
    run(3, 1'b0);
    check("pre-reset clk,mode", int'({clk_o, mode}), 3'b101);
    cycle(1'b1, 1'b0, 1'b0);
    check("mid-op reset outputs", int'({tick, clk_o, mode, mode_chg}), 0);
    edges_to_tick(1'b1, e);
    check("first tick after mid-op reset", e, 4);

    check("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
